// File: rtl/tmds_pkg.sv
// tmds_pkg: control-token constants, FSM state encoding and symbol width for the TMDS receive path.
package tmds_pkg;

    localparam int SYM_W = 10;

    localparam logic [SYM_W-1:0] TOKEN_C00 = 10'b1101010100;
    localparam logic [SYM_W-1:0] TOKEN_C01 = 10'b0010101011;
    localparam logic [SYM_W-1:0] TOKEN_C10 = 10'b0101010100;
    localparam logic [SYM_W-1:0] TOKEN_C11 = 10'b1010101011;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    // Bit offset into the 20-bit window steps 0..9 and wraps.
    function automatic logic [3:0] next_offset(input logic [3:0] off);
        return (off == 4'd9) ? 4'd0 : off + 4'd1;
    endfunction

endpackage

// File: rtl/tmds_symbol_decode.sv
// tmds_symbol_decode: combinational decode of one aligned 10-bit TMDS symbol into
// a control-token flag with its C1/C0 value, and the 8-bit data byte it would carry.
module tmds_symbol_decode
    import tmds_pkg::*;
(
    input  logic [SYM_W-1:0] q,
    output logic             is_token,
    output logic [1:0]       ctrl,
    output logic [7:0]       data
);

    logic [7:0] dp;

    always_comb begin
        is_token = 1'b1;
        ctrl     = 2'b00;
        case (q)
            TOKEN_C00: ctrl = 2'b00;
            TOKEN_C01: ctrl = 2'b01;
            TOKEN_C10: ctrl = 2'b10;
            TOKEN_C11: ctrl = 2'b11;
            default:   is_token = 1'b0;
        endcase
    end

    // q[9] undoes the DC-balance inversion, q[8] selects XOR or XNOR chaining.
    always_comb begin
        dp      = q[9] ? ~q[7:0] : q[7:0];
        data    = 8'h00;
        data[0] = dp[0];
        for (int i = 1; i < 8; i++) begin
            data[i] = q[8] ? (dp[i] ^ dp[i-1]) : ~(dp[i] ^ dp[i-1]);
        end
    end

endmodule

// File: rtl/tmds_decoder.sv
// tmds_decoder: one TMDS channel receiver - finds word alignment from control-token runs and decodes symbols.
// Defining TMDS_DEC_ERRCNT_EN adds err_count, a saturating count of short control runs ending while locked.
module tmds_decoder
    import tmds_pkg::*;
#(
    parameter int LOCK_COUNT = 8,
    parameter int TIMEOUT    = 4096,
    parameter int TIMEOUT_W  = 12
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ce,
    input  logic [SYM_W-1:0] sym_in,
    output logic [7:0]       data,
    output logic [1:0]       ctrl,
    output logic             de,
    output logic             locked,
`ifdef TMDS_DEC_ERRCNT_EN
    output logic [15:0]      err_count,
`endif
    output logic [3:0]       offset
);

    localparam int RUN_W = $clog2(LOCK_COUNT + 1);

    logic [SYM_W-1:0]   prev;
    logic [2*SYM_W-1:0] cat;
    logic [SYM_W-1:0]   sym;
    logic               is_token;
    logic [1:0]         tok_ctrl;
    logic [7:0]         dec_data;

    state_t             state, state_nx;
    logic [3:0]         offset_nx;
    logic [RUN_W-1:0]   run, run_nx;
    logic [TIMEOUT_W-1:0] timer, timer_nx;
    logic [7:0]         data_nx;
    logic [1:0]         ctrl_nx;
    logic               de_nx;

    assign cat = {sym_in, prev};
    assign sym = cat[offset +: SYM_W];

    tmds_symbol_decode u_decode (
        .q        (sym),
        .is_token (is_token),
        .ctrl     (tok_ctrl),
        .data     (dec_data)
    );

    // prev is a pure data pipeline stage, so it keeps loading through reset.
    always_ff @(posedge clock) begin
        if (ce) begin
            prev <= sym_in;
        end
    end

    always_comb begin
        state_nx  = state;
        offset_nx = offset;
        run_nx    = run;
        timer_nx  = timer;
        case (state)
            SEARCH: begin
                if (is_token) begin
                    state_nx = VERIFY;
                    run_nx   = RUN_W'(1);
                end else begin
                    offset_nx = next_offset(offset);
                end
            end
            VERIFY: begin
                if (is_token) begin
                    run_nx = run + RUN_W'(1);
                    if (run == RUN_W'(LOCK_COUNT - 1)) begin
                        state_nx = LOCKED;
                        timer_nx = '0;
                    end
                end else begin
                    state_nx  = SEARCH;
                    run_nx    = '0;
                    offset_nx = next_offset(offset);
                end
            end
            LOCKED: begin
                // A token always clears the timer, even on the cycle it would expire.
                if (is_token) begin
                    timer_nx = '0;
                    if (run != RUN_W'(LOCK_COUNT)) begin
                        run_nx = run + RUN_W'(1);
                    end
                end else begin
                    run_nx = '0;
                    if (timer == TIMEOUT_W'(TIMEOUT - 1)) begin
                        state_nx = SEARCH;
                        timer_nx = '0;
                    end else begin
                        timer_nx = timer + TIMEOUT_W'(1);
                    end
                end
            end
            default: begin
                state_nx  = SEARCH;
                offset_nx = '0;
                run_nx    = '0;
                timer_nx  = '0;
            end
        endcase
    end

    // Outputs follow the state being entered so de/ctrl are only ever seen alongside locked=1.
    always_comb begin
        data_nx = data;
        ctrl_nx = ctrl;
        de_nx   = 1'b0;
        if (state_nx != LOCKED) begin
            data_nx = 8'h00;
            ctrl_nx = 2'b00;
        end else if (is_token) begin
            ctrl_nx = tok_ctrl;
        end else begin
            de_nx   = 1'b1;
            data_nx = dec_data;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state  <= SEARCH;
            offset <= '0;
            run    <= '0;
            timer  <= '0;
            data   <= 8'h00;
            ctrl   <= 2'b00;
            de     <= 1'b0;
            locked <= 1'b0;
        end else if (ce) begin
            state  <= state_nx;
            offset <= offset_nx;
            run    <= run_nx;
            timer  <= timer_nx;
            data   <= data_nx;
            ctrl   <= ctrl_nx;
            de     <= de_nx;
            locked <= (state_nx == LOCKED);
        end
    end

`ifdef TMDS_DEC_ERRCNT_EN
    logic short_run_end;

    assign short_run_end = (state == LOCKED) && !is_token &&
                           (run != '0) && (run < RUN_W'(LOCK_COUNT));

    always_ff @(posedge clock) begin
        if (!reset) begin
            err_count <= 16'h0000;
        end else if (ce && short_run_end && (err_count != 16'hFFFF)) begin
            err_count <= err_count + 16'h0001;
        end
    end
`endif

endmodule

// File: tb/tb_tmds_decoder.sv
// tb_tmds_decoder: directed bench for tmds_decoder with a scoreboard of encoded bytes.
// Build with TMDS_DEC_ERRCNT_EN defined to also cover err_count.
module tb_tmds_decoder;

    localparam logic [9:0] TK00 = 10'b1101010100;
    localparam logic [9:0] TK01 = 10'b0010101011;
    localparam logic [9:0] TK10 = 10'b0101010100;
    localparam logic [9:0] TK11 = 10'b1010101011;

    logic       clock = 1'b0;
    logic       reset;
    logic       ce;
    logic [9:0] sym_in;
    logic [7:0] data;
    logic [1:0] ctrl;
    logic       de;
    logic       locked;
    logic [3:0] offset;
`ifdef TMDS_DEC_ERRCNT_EN
    logic [15:0] err_count;
`endif

    always #5 clock = ~clock;

    tmds_decoder dut (
        .clock     (clock),
        .reset     (reset),
        .ce        (ce),
        .sym_in    (sym_in),
        .data      (data),
        .ctrl      (ctrl),
        .de        (de),
        .locked    (locked),
`ifdef TMDS_DEC_ERRCNT_EN
        .err_count (err_count),
`endif
        .offset    (offset)
    );

    typedef struct {
        logic [7:0] b;
        int         at;
    } exp_t;

    exp_t sb[$];
    int   total  = 0;
    int   bad    = 0;
    int   edge_n = 0;
    int   rd     = 0;

    // Reference DVI 1.0 TMDS encoder with running disparity held in rd.
    function automatic logic [9:0] tmds_encode(input logic [7:0] d);
        logic [8:0] qm;
        logic [9:0] q;
        int n1d, n1q, n0q;
        n1d   = $countones(d);
        qm[0] = d[0];
        if (n1d > 4 || (n1d == 4 && !d[0])) begin
            for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ d[i]);
            qm[8] = 1'b0;
        end else begin
            for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ d[i];
            qm[8] = 1'b1;
        end
        n1q = $countones(qm[7:0]);
        n0q = 8 - n1q;
        if (rd == 0 || n1q == n0q) begin
            q  = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
            rd = qm[8] ? (rd + n1q - n0q) : (rd + n0q - n1q);
        end else if ((rd > 0 && n1q > n0q) || (rd < 0 && n0q > n1q)) begin
            q  = {1'b1, qm[8], ~qm[7:0]};
            rd = rd + (qm[8] ? 2 : 0) + n0q - n1q;
        end else begin
            q  = {1'b0, qm[8], qm[7:0]};
            rd = rd - (qm[8] ? 0 : 2) + n1q - n0q;
        end
        return q;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idleGap();
        ce     = 1'b0;
        sym_in = 10'($urandom);
        @(posedge clock);
        #1;
    endtask

    // One ce edge with word w; a pushed byte is due on de/data exactly one ce edge later.
    task automatic applyStimulus(input logic [9:0] w, input bit push, input logic [7:0] b);
        exp_t e;
        if ($urandom_range(0, 7) == 0) idleGap();
        sym_in = w;
        ce     = 1'b1;
        if (push) begin
            e.b  = b;
            e.at = edge_n + 2;
            sb.push_back(e);
        end
        @(posedge clock);
        #1;
        edge_n++;
        ce = 1'b0;
        if (sb.size() > 0 && sb[0].at == edge_n) begin
            e = sb.pop_front();
            checkOutput("de_data", 32'(de), 32'd1);
            checkOutput("data", 32'(data), 32'(e.b));
        end else begin
            checkOutput("de_idle", 32'(de), 32'd0);
        end
    endtask

    task automatic doReset(input logic [9:0] w);
        reset  = 1'b0;
        ce     = 1'b1;
        sym_in = w;
        @(posedge clock);
        #1;
        edge_n++;
        reset = 1'b1;
        ce    = 1'b0;
        sb.delete();
        checkOutput("rst_locked", 32'(locked), 32'd0);
        checkOutput("rst_de", 32'(de), 32'd0);
        checkOutput("rst_data", 32'(data), 32'd0);
        checkOutput("rst_ctrl", 32'(ctrl), 32'd0);
        checkOutput("rst_offset", 32'(offset), 32'd0);
    endtask

    initial begin
        logic [9:0] w11;
        logic [9:0] w;
        logic [7:0] b;
        logic [7:0] bytes3 [4];

        reset  = 1'b0;
        ce     = 1'b0;
        sym_in = 10'd0;
        bytes3 = '{8'h00, 8'hFF, 8'h55, 8'hA5};

        $display("[TB] test 1: lock on tokens 00 at offset 0");
        doReset(TK00);
        for (int i = 1; i <= 20; i++) begin
            applyStimulus(TK00, 1'b0, 8'h00);
            if (i == 7) checkOutput("t1_locked_7", 32'(locked), 32'd0);
            if (i == 8) begin
                checkOutput("t1_locked_8", 32'(locked), 32'd1);
                checkOutput("t1_offset", 32'(offset), 32'd0);
            end
        end
        checkOutput("t1_ctrl", 32'(ctrl), 32'd0);

        $display("[TB] test 2: tokens 11 shifted by 3 bits");
        w11 = {TK11[6:0], TK11[9:7]};
        doReset(w11);
        for (int i = 1; i <= 40; i++) begin
            applyStimulus(w11, 1'b0, 8'h00);
            if (i == 3)  checkOutput("t2_offset_3", 32'(offset), 32'd3);
            if (i == 10) checkOutput("t2_locked_10", 32'(locked), 32'd0);
            if (i == 11) checkOutput("t2_locked_11", 32'(locked), 32'd1);
        end
        checkOutput("t2_offset", 32'(offset), 32'd3);
        checkOutput("t2_ctrl", 32'(ctrl), 32'd3);
        checkOutput("t2_locked", 32'(locked), 32'd1);

        $display("[TB] test 3: data bytes 00 FF 55 A5");
        doReset(TK00);
        for (int i = 0; i < 12; i++) applyStimulus(TK00, 1'b0, 8'h00);
        checkOutput("t3_locked", 32'(locked), 32'd1);
        rd = 0;
        for (int i = 0; i < 4; i++) applyStimulus(tmds_encode(bytes3[i]), 1'b1, bytes3[i]);
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(TK10, 1'b0, 8'h00);
            if (i == 2) begin
                checkOutput("t3_ctrl", 32'(ctrl), 32'd2);
                checkOutput("t3_data_hold", 32'(data), 32'hA5);
            end
        end

        $display("[TB] test 4: timeout after 4096 data symbols");
        rd = 0;
        for (int i = 0; i < 4096; i++) begin
            b = 8'($urandom);
            w = tmds_encode(b);
            applyStimulus(w, (i < 4095), b);
        end
        checkOutput("t4_locked_before", 32'(locked), 32'd1);
        applyStimulus(TK00, 1'b0, 8'h00);
        checkOutput("t4_locked_after", 32'(locked), 32'd0);
        checkOutput("t4_data", 32'(data), 32'd0);
        checkOutput("t4_ctrl", 32'(ctrl), 32'd0);
        checkOutput("t4_offset", 32'(offset), 32'd0);
        checkOutput("t4_sb_empty", 32'(sb.size()), 32'd0);
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(TK00, 1'b0, 8'h00);
            if (i == 7) checkOutput("t4_relock_7", 32'(locked), 32'd0);
            if (i == 8) checkOutput("t4_relock_8", 32'(locked), 32'd1);
        end

        $display("[TB] test 5: reset mid-line");
        rd = 0;
        for (int i = 0; i < 5; i++) begin
            b = 8'($urandom);
            applyStimulus(tmds_encode(b), 1'b1, b);
        end
        checkOutput("t5_locked_pre", 32'(locked), 32'd1);
        doReset(tmds_encode(8'h3C));
        for (int i = 1; i <= 18; i++) begin
            applyStimulus(TK00, 1'b0, 8'h00);
            if (i == 1)  checkOutput("t5_offset_1", 32'(offset), 32'd1);
            if (i == 17) checkOutput("t5_locked_17", 32'(locked), 32'd0);
            if (i == 18) checkOutput("t5_locked_18", 32'(locked), 32'd1);
        end
        checkOutput("t5_offset", 32'(offset), 32'd0);

`ifdef TMDS_DEC_ERRCNT_EN
        $display("[TB] test 6: short control runs while locked");
        checkOutput("t6_err_start", 32'(err_count), 32'd0);
        for (int burst = 0; burst < 3; burst++) begin
            rd = 0;
            for (int i = 0; i < 5; i++) begin
                b = 8'($urandom);
                applyStimulus(tmds_encode(b), 1'b1, b);
            end
            for (int i = 0; i < ((burst == 2) ? 2 : 3); i++) applyStimulus(TK01, 1'b0, 8'h00);
        end
        checkOutput("t6_err_count", 32'(err_count), 32'd2);
        checkOutput("t6_locked", 32'(locked), 32'd1);
        checkOutput("t6_sb_empty", 32'(sb.size()), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
